stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Consumer end of the divider's count-tick interface. Counts tick pulses as hundredths of a second into a 4-digit BCD value SS.hh (00.00 to 99.99).
- Start/stop and clear are controlled by a small FSM.
- The BCD output feeds the display multiplexer. The multiplexer is clocked from the divider's display clock.
- Inputs are single-cycle, already-debounced pulses. All logic runs on the single system clock.

Parameters:
- HALT_AT_MAX, default 1: 1 = stop at 99.99 with sticky overflow; 0 = wrap to 00.00 with a one-cycle overflow pulse.
- TICK_EDGE, default 1: 1 = count only on the rising edge of tick (a multi-cycle strobe counts once); 0 = count every cycle tick is high.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- tick  input  1  count enable from the clock divider, nominally high one cycle per 10 ms
- start_stop  input  1  one-cycle pulse; toggles run/pause
- clear  input  1  one-cycle pulse; zero the count and return to idle
- lap  input  1  one-cycle pulse; freeze/release display (see Optional Feature)
- count_bcd  output  16  {sec_tens, sec_units, tenths, hundredths}, 4 bits each, BCD 0-9
- running  output  1  high while the FSM is in RUN
- overflow  output  1  max-count indication; semantics set by HALT_AT_MAX
- held  output  1  display frozen by lap

Behaviour:
- Reset (reset=0, asynchronous):
  - count_bcd=16'h0000, FSM=IDLE, running=0, overflow=0, held=0.
  - Internal tick delay register is set to 0.
  - Release is synchronous to clk by the instantiating design.
- FSM states: IDLE, RUN, PAUSE, FULL. All outputs are registered.
  - IDLE: count is 0. start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - RUN, HALT_AT_MAX=1: an increment from 99.99 -> FULL; count stays 99.99; overflow=1 (sticky).
  - PAUSE: count is held. start_stop -> RUN.
  - FULL: start_stop is ignored; count is held at 16'h9999.
  - Any state: clear -> IDLE, count=0, overflow=0, held=0.
- Increment enable inc:
  - TICK_EDGE=1: inc = tick & ~tick_q & (state==RUN), where tick_q is tick registered.
  - TICK_EDGE=0: inc = tick & (state==RUN).
- Latency: a tick sampled at edge N updates count_bcd at edge N, visible in cycle N+1. Exactly one increment per qualified tick.
- BCD arithmetic, ripple carry in the same cycle:
  - hundredths 9->0 carries into tenths.
  - tenths 9->0 carries into sec_units.
  - sec_units 9->0 carries into sec_tens.
  - No digit ever holds a value above 9.
- Wrap at 99.99, HALT_AT_MAX=0: count goes to 00.00; overflow is high for exactly that one cycle; state stays RUN.
- Simultaneous events in the same cycle:
  - clear beats start_stop, tick and lap.
  - tick + start_stop in RUN: the increment is applied AND the state goes to PAUSE.
  - tick + start_stop in PAUSE: no increment; the state goes to RUN.
  - tick in IDLE or PAUSE: ignored. tick_q still tracks tick, so a tick held high across resume does not count when TICK_EDGE=1.
- running = (state==RUN); it changes on the edge after the start_stop pulse.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- When defined, in RUN or PAUSE:
  - A lap pulse captures the live count into a display register and sets held=1. count_bcd shows the captured value while the internal count keeps running.
  - The next lap pulse clears held; count_bcd shows the live count again from the following cycle.
- lap is ignored in IDLE and FULL. clear and reset force held=0.
- When not defined: the lap port exists but is ignored; held is tied 0; count_bcd is always the live count.

Test Plan:
- Reset low mid-run with count=12.34 -> count_bcd=0000, running=0, overflow=0 immediately, without waiting for a clock edge. After release, tick pulses are ignored until start_stop.
- start_stop, then 1234 single-cycle ticks -> count_bcd=16'h1234, running=1. start_stop, then 50 more ticks -> count is still 1234, running=0.
- HALT_AT_MAX=1: run to 99.98, 2 ticks -> 9999, then state FULL, overflow=1 sticky. start_stop is ignored. clear -> 0000, overflow=0, IDLE.
- HALT_AT_MAX=0: from 99.99, one tick -> 0000, overflow high exactly 1 cycle, running stays 1.
- TICK_EDGE=1: tick held high 5 cycles -> +1 only (e.g. 00.09->00.10 carry checked). tick and clear in the same cycle -> 0000. tick and start_stop in the same cycle while running -> +1, then paused.
- With STOPWATCH_LAP_HOLD_EN: lap at 03.00, 200 ticks -> count_bcd=0300, held=1. Second lap -> 0500 next cycle, held=0.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch core: counts divider ticks as BCD SS.hh under a run/pause FSM.
// Optional lap display hold enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_core #(
    parameter bit HALT_AT_MAX = 1'b1,
    parameter bit TICK_EDGE   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] count_bcd,
    output logic        running,
    output logic        overflow,
    output logic        held
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        FULL
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [15:0] cnt_inc;
    logic        ovf_nx;
    logic        tick_q;
    logic        tick_ok;
    logic        inc;
    logic        at_max;
    logic        carry;

    assign tick_ok = TICK_EDGE ? (tick & ~tick_q) : tick;
    assign inc     = tick_ok & (state == RUN);
    assign at_max  = (cnt == 16'h9999);
    assign running = (state == RUN);

    // Ripple BCD increment; a digit at 9 or above rolls to 0 and carries.
    always_comb begin
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt[4*i +: 4] >= 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ovf_nx   = HALT_AT_MAX ? overflow : 1'b0;
        if (clear) begin
            state_nx = IDLE;
            cnt_nx   = 16'h0000;
            ovf_nx   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_stop) state_nx = RUN;
                end
                RUN: begin
                    if (start_stop) state_nx = PAUSE;
                    if (inc) begin
                        if (!at_max) begin
                            cnt_nx = cnt_inc;
                        end else if (HALT_AT_MAX) begin
                            // Saturation takes priority over a same-cycle pause.
                            state_nx = FULL;
                            ovf_nx   = 1'b1;
                        end else begin
                            cnt_nx = 16'h0000;
                            ovf_nx = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start_stop) state_nx = RUN;
                end
                FULL: begin
                    state_nx = FULL;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 16'h0000;
            overflow <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            overflow <= ovf_nx;
            tick_q   <= tick;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic [15:0] disp;
    logic        held_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q <= 1'b0;
            disp   <= 16'h0000;
        end else if (clear) begin
            held_q <= 1'b0;
        end else if (lap && (state == RUN || state == PAUSE)) begin
            held_q <= ~held_q;
            if (!held_q) disp <= cnt;
        end
    end

    assign held      = held_q;
    assign count_bcd = held_q ? disp : cnt;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign held       = 1'b0;
    assign count_bcd  = cnt;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: default instance plus a wrap/level-tick instance,
// both compared every cycle against an integer-count reference model.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] bcd_a;
    logic [15:0] bcd_b;
    logic        run_a;
    logic        run_b;
    logic        ovf_a;
    logic        ovf_b;
    logic        held_a;
    logic        held_b;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    stopwatch_core dut_a (
        .clk(clk), .reset(reset), .tick(tick),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .count_bcd(bcd_a), .running(run_a),
        .overflow(ovf_a), .held(held_a)
    );

    stopwatch_core #(.HALT_AT_MAX(1'b0), .TICK_EDGE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .tick(tick),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .count_bcd(bcd_b), .running(run_b),
        .overflow(ovf_b), .held(held_b)
    );

    // mode: 0 idle, 1 run, 2 pause, 3 full; cnt is plain centiseconds.
    typedef struct {
        int mode;
        int cnt;
        bit ovf;
        bit held;
        int disp;
        bit tq;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.mode = 0; m.cnt = 0; m.ovf = 0;
        m.held = 0; m.disp = 0; m.tq = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, bit halt, bit edg,
                                  bit tk, bit ss, bit clr, bit lp);
        mdl_t n;
        bit   inc;
        n = m;
        n.tq = tk;
        if (!halt) n.ovf = 0;
        inc = tk && (!edg || !m.tq) && (m.mode == 1);
        if (clr) begin
            n.mode = 0; n.cnt = 0; n.ovf = 0; n.held = 0;
            return n;
        end
        if (LAP_EN && lp && (m.mode == 1 || m.mode == 2)) begin
            n.held = !m.held;
            if (!m.held) n.disp = m.cnt;
        end
        if (m.mode == 0 && ss) begin
            n.mode = 1;
        end else if (m.mode == 2 && ss) begin
            n.mode = 1;
        end else if (m.mode == 1) begin
            if (ss) n.mode = 2;
            if (inc) begin
                n.cnt = m.cnt + 1;
                if (n.cnt == 10000) begin
                    n.ovf = 1;
                    if (halt) begin
                        n.cnt = 9999;
                        n.mode = 3;
                    end else begin
                        n.cnt = 0;
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_bcd(mdl_t m);
        return to_bcd(m.held ? m.disp : m.cnt);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= step(ma, 1'b1, 1'b1, tick, start_stop, clear, lap);
            mb <= step(mb, 1'b0, 1'b0, tick, start_stop, clear, lap);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_bcd", bcd_a, exp_bcd(ma));
            chk("a_run", 16'(run_a), 16'(ma.mode == 1));
            chk("a_ovf", 16'(ovf_a), 16'(ma.ovf));
            chk("a_held", 16'(held_a), 16'(ma.held));
            chk("b_bcd", bcd_b, exp_bcd(mb));
            chk("b_run", 16'(run_b), 16'(mb.mode == 1));
            chk("b_ovf", 16'(ovf_b), 16'(mb.ovf));
            chk("b_held", 16'(held_b), 16'(mb.held));
        end
    end

    task automatic cyc(input bit t, input bit s,
                       input bit c, input bit l);
        @(negedge clk);
        tick = t;
        start_stop = s;
        clear = c;
        lap = l;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_pulses(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            idle_cyc();
        end
    endtask

    task automatic ss_pulse();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cyc();
    endtask

    initial begin
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bcd", bcd_a, 16'h0000);
        chk("rst_run", 16'(run_a), 16'h0);
        chk("rst_ovf", 16'(ovf_a), 16'h0);
        reset = 1'b1;

        tick_pulses(5);
        chk("idle_ignore", bcd_a, 16'h0000);

        ss_pulse();
        tick_pulses(1234);
        chk("cnt1234_a", bcd_a, 16'h1234);
        chk("cnt1234_run", 16'(run_a), 16'h1);
        chk("cnt1234_b", bcd_b, 16'h1234);
        ss_pulse();
        tick_pulses(50);
        chk("pause_a", bcd_a, 16'h1234);
        chk("pause_run", 16'(run_a), 16'h0);

        ss_pulse();
        tick_pulses(3);
        chk("resume_a", bcd_a, 16'h1237);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_bcd", bcd_a, 16'h0000);
        chk("async_run", 16'(run_a), 16'h0);
        chk("async_ovf", 16'(ovf_a), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        tick_pulses(4);
        chk("post_rst_idle", bcd_a, 16'h0000);

        ss_pulse();
        tick_pulses(9);
        chk("edge_9", bcd_a, 16'h0009);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cyc();
        chk("edge_hold_a", bcd_a, 16'h0010);
        chk("level_hold_b", bcd_b, 16'h0014);

        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cyc();
        chk("tick_ss_a", bcd_a, 16'h0011);
        chk("tick_ss_run", 16'(run_a), 16'h0);
        chk("tick_ss_b", bcd_b, 16'h0015);

        ss_pulse();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle_cyc();
        chk("tick_clr_a", bcd_a, 16'h0000);
        chk("tick_clr_run", 16'(run_a), 16'h0);
        chk("tick_clr_b", bcd_b, 16'h0000);

`ifdef STOPWATCH_LAP_HOLD_EN
        ss_pulse();
        tick_pulses(300);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        tick_pulses(200);
        chk("lap_frozen", bcd_a, 16'h0300);
        chk("lap_held", 16'(held_a), 16'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        chk("lap_release", bcd_a, 16'h0500);
        chk("lap_unheld", 16'(held_a), 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cyc();
`endif

        ss_pulse();
        tick_pulses(9998);
        chk("max_m1_a", bcd_a, 16'h9998);
        chk("max_m1_b", bcd_b, 16'h9998);
        tick_pulses(1);
        chk("max_a", bcd_a, 16'h9999);
        chk("max_ovf_a", 16'(ovf_a), 16'h0);
        tick_pulses(1);
        chk("full_a", bcd_a, 16'h9999);
        chk("full_ovf_a", 16'(ovf_a), 16'h1);
        chk("full_run_a", 16'(run_a), 16'h0);
        chk("wrap_b", bcd_b, 16'h0000);
        chk("wrap_ovf_b", 16'(ovf_b), 16'h1);
        chk("wrap_run_b", 16'(run_b), 16'h1);
        idle_cyc();
        chk("wrap_ovf_drop_b", 16'(ovf_b), 16'h0);
        chk("full_sticky_a", 16'(ovf_a), 16'h1);
        ss_pulse();
        chk("full_ss_a", bcd_a, 16'h9999);
        chk("full_ss_run", 16'(run_a), 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cyc();
        chk("full_clr_a", bcd_a, 16'h0000);
        chk("full_clr_ovf", 16'(ovf_a), 16'h0);

        repeat (4000) begin
            cyc(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 199) == 0),
                1'($urandom_range(0, 29) == 0));
        end
        idle_cyc();
        idle_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
